// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//
// RV32/RV64 execute unit for the EX stage. It decodes alu_op/funct7/funct3,
// computes single-cycle ALU results and registers them. It can also run an
// iterative multiply/divide datapath. A valid/ready handshake on both sides
// lets multi-cycle operations stall the pipeline.
//
// Optional feature macro: RV_MDU_EN
//   defined   : the R-type funct7=0000001 group runs on the iterative
//               shift-add multiplier / restoring divider. Latency is XLEN+1.
//   undefined : that group decodes as illegal (latency 1, result 0). The
//               ITER state and the MDU datapath are not built.
//
// Parameters
//   XLEN        operand/result width, 32 or 64
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   in_valid    operation presented
//   in_ready    unit can accept an operation this cycle
//               (combinational from state and out_ready)
//   alu_op      00 ADD, 01 SUB, 10 R-type, 11 I-type
//   funct7      instruction funct7 (I-type uses only bit 5, for SRAI)
//   funct3      instruction funct3
//   op_a, op_b  operands
//   out_valid   result/illegal are valid
//   out_ready   consumer takes the result
//   result      registered result
//   illegal     unsupported decode combination; result is 0
// -----------------------------------------------------------------------------
module alu_exec_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      alu_op,
   input  logic [6:0]      funct7,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            illegal
);

   localparam int SHW = $clog2(XLEN);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DONE = 2'd2;
`ifdef RV_MDU_EN
   localparam logic [1:0] ST_ITER = 2'd1;
`endif

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            illegal_q, illegal_d;
   logic            accept;

   // Decode outputs: effective funct3 and the "alternate" flag (SUB / SRA).
   logic [2:0]      dec_f3;
   logic            dec_alt;
   logic            dec_illegal;
   logic [SHW-1:0]  shamt;
   logic [XLEN-1:0] alu_res;

`ifdef RV_MDU_EN
   logic              dec_mdu;
   logic [SHW-1:0]    cnt_q, cnt_d;
   // MUL: {partial high, multiplier shifting out}. DIV: {remainder, dividend shifting out / quotient shifting in}.
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   opb_q, opb_d;
   logic [1:0]        sel_q, sel_d;
   logic              is_div_q, is_div_d;
   logic              neg_q, neg_d;
   logic              div0_q, div0_d;

   logic              signed_a, signed_b, a_neg, b_neg, neg_op;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic [XLEN:0]     mul_sum, div_trial, div_diff;
   logic [2*XLEN-1:0] mul_next, div_next, acc_next, prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix, mdu_res;
   logic              last_iter;
`endif

   // ---------------------------------------------------------------- decode
   always_comb begin
      dec_f3      = funct3;
      dec_alt     = 1'b0;
      dec_illegal = 1'b0;
`ifdef RV_MDU_EN
      dec_mdu     = 1'b0;
`endif
      case (alu_op)
         2'b00: dec_f3 = 3'b000;
         2'b01: begin
            dec_f3  = 3'b000;
            dec_alt = 1'b1;
         end
         2'b10: begin
            if (funct7 == 7'b0000000) begin
               dec_alt = 1'b0;
            end else if (funct7 == 7'b0100000) begin
               if (funct3 == 3'b000 || funct3 == 3'b101)
                  dec_alt = 1'b1;
               else
                  dec_illegal = 1'b1;
            end else if (funct7 == 7'b0000001) begin
`ifdef RV_MDU_EN
               dec_mdu = 1'b1;
`else
               dec_illegal = 1'b1;
`endif
            end else begin
               dec_illegal = 1'b1;
            end
         end
         default: begin
            // I-type: only SRAI uses funct7[5]; ADDI never becomes SUB.
            dec_alt = (funct3 == 3'b101) & funct7[5];
         end
      endcase
   end

   // ------------------------------------------------------ single-cycle ALU
   assign shamt = op_b[SHW-1:0];

   always_comb begin
      alu_res = '0;
      case (dec_f3)
         3'b000: alu_res = dec_alt ? (op_a - op_b) : (op_a + op_b);
         3'b001: alu_res = op_a << shamt;
         3'b010: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         3'b011: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         3'b100: alu_res = op_a ^ op_b;
         3'b101: alu_res = dec_alt ? XLEN'($signed(op_a) >>> shamt) : (op_a >> shamt);
         3'b110: alu_res = op_a | op_b;
         default: alu_res = op_a & op_b;
      endcase
   end

`ifdef RV_MDU_EN
   // ------------------------------------------------- MDU operand prepare
   // Operands are converted to magnitudes at accept. neg_op records whether
   // the selected output (product, quotient or remainder) must be negated.
   always_comb begin
      signed_a = 1'b0;
      signed_b = 1'b0;
      neg_op   = 1'b0;
      case (funct3)
         3'b000, 3'b001, 3'b100, 3'b110: begin
            signed_a = 1'b1;
            signed_b = 1'b1;
         end
         3'b010: signed_a = 1'b1;
         default: ;
      endcase
      a_neg = signed_a & op_a[XLEN-1];
      b_neg = signed_b & op_b[XLEN-1];
      mag_a = a_neg ? (-op_a) : op_a;
      mag_b = b_neg ? (-op_b) : op_b;
      case (funct3)
         3'b000, 3'b001, 3'b100: neg_op = a_neg ^ b_neg;
         3'b010, 3'b110:         neg_op = a_neg;   // MULHSU, and remainder follows dividend
         default:                neg_op = 1'b0;
      endcase
   end

   // ----------------------------------------------------- MDU iteration step
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      mul_next  = {mul_sum, acc_q[XLEN-1:1]};

      div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_diff  = div_trial - {1'b0, opb_q};
      // A borrow means the trial remainder is below the divisor: restore it.
      div_next  = div_diff[XLEN] ? {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                 : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};

      acc_next  = is_div_q ? div_next : mul_next;

      prod_fix  = neg_q ? (-acc_next) : acc_next;
      // The magnitude divider naturally gives remainder = |op_a| on divide
      // by zero. Only the quotient needs forcing to all ones.
      quo_fix   = div0_q ? '1 : (neg_q ? (-acc_next[XLEN-1:0]) : acc_next[XLEN-1:0]);
      rem_fix   = neg_q ? (-acc_next[2*XLEN-1:XLEN]) : acc_next[2*XLEN-1:XLEN];

      if (is_div_q)
         mdu_res = sel_q[1] ? rem_fix : quo_fix;
      else
         mdu_res = (sel_q == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

      last_iter = (cnt_q == SHW'(XLEN-1));
   end
`endif

   // ------------------------------------------------------- control / FSM
   assign in_ready = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
   assign accept   = in_valid & in_ready;

   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      illegal_d = illegal_q;
`ifdef RV_MDU_EN
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opb_d     = opb_q;
      sel_d     = sel_q;
      is_div_d  = is_div_q;
      neg_d     = neg_q;
      div0_d    = div0_q;
`endif
      case (state_q)
         ST_IDLE: ;
         ST_DONE: if (out_ready) state_d = ST_IDLE;
`ifdef RV_MDU_EN
         ST_ITER: begin
            acc_d = acc_next;
            cnt_d = cnt_q + 1'b1;
            if (last_iter) begin
               state_d   = ST_DONE;
               result_d  = mdu_res;
               illegal_d = 1'b0;
               cnt_d     = '0;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase

      // Accept can only happen from IDLE or from DONE with out_ready. That
      // makes DONE->DONE / DONE->ITER back-to-back transfers possible.
      if (accept) begin
`ifdef RV_MDU_EN
         if (dec_mdu) begin
            state_d  = ST_ITER;
            cnt_d    = '0;
            acc_d    = {{XLEN{1'b0}}, mag_a};
            opb_d    = mag_b;
            sel_d    = funct3[1:0];
            is_div_d = funct3[2];
            neg_d    = neg_op;
            div0_d   = funct3[2] & (op_b == '0);
         end else
`endif
         begin
            state_d   = ST_DONE;
            result_d  = dec_illegal ? '0 : alu_res;
            illegal_d = dec_illegal;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         result_q  <= '0;
         illegal_q <= 1'b0;
`ifdef RV_MDU_EN
         cnt_q     <= '0;
         acc_q     <= '0;
         opb_q     <= '0;
         sel_q     <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         div0_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         illegal_q <= illegal_d;
`ifdef RV_MDU_EN
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opb_q     <= opb_d;
         sel_q     <= sel_d;
         is_div_q  <= is_div_d;
         neg_q     <= neg_d;
         div0_q    <= div0_d;
`endif
      end
   end

   assign out_valid = (state_q == ST_DONE);
   assign result    = result_q;
   assign illegal   = illegal_q;

endmodule
